// File: rtl/branch_update_queue_pkg.sv
// Shared types and helpers for the in-order branch resolution queue.
// The entry record and the misprediction/redirect rules live here.
package branch_update_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        act_taken;
    logic [31:0] act_target;
  } bq_entry_s;

  // A not-taken branch never mispredicts on target, only on direction.
  function automatic logic bq_mispredict(input bq_entry_s e);
    return (e.act_taken != e.pred_taken) ||
           (e.act_taken && (e.act_target != e.pred_target));
  endfunction

  function automatic logic [31:0] bq_redirect(input bq_entry_s e);
    return e.act_taken ? e.act_target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_update_queue.sv
// In-order branch resolution queue feeding the gshare update port.
// Allocates in fetch order, resolves by tag, retires one resolved head per cycle.
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TAG_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic [31:0]          alloc_pc_i,
  input  logic                 alloc_pred_taken_i,
  input  logic [31:0]          alloc_pred_target_i,
  output logic [TAG_WIDTH-1:0] alloc_tag_o,
  input  logic                 resolve_valid_i,
  input  logic [TAG_WIDTH-1:0] resolve_tag_i,
  input  logic                 resolve_taken_i,
  input  logic [31:0]          resolve_target_i,
  input  logic                 flush_i,
  output logic                 update_en_o,
  output logic [31:0]          update_pc_o,
  output logic                 actual_taken_o,
  output logic [31:0]          actual_target_o,
  output logic                 mispredict_o,
  output logic [31:0]          redirect_pc_o,
  output logic [TAG_WIDTH:0]   count_o
);

  localparam int PW = TAG_WIDTH + 1;

  bq_entry_s ent_q [DEPTH];

  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]        count;
  logic [TAG_WIDTH-1:0] head_idx, tail_idx;
  bq_entry_s            head_ent, res_ent;
  logic                 retire, mispred, do_alloc, do_resolve;

  logic        update_en_q, mispredict_q, actual_taken_q;
  logic [31:0] update_pc_q, actual_target_q, redirect_pc_q;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];
  assign count    = tail_q - head_q;

  // Ready and tag come from registered pointers only, so a retire in the
  // same cycle never opens a slot for that cycle's allocation.
  assign alloc_ready_o = (count < PW'(DEPTH));
  assign alloc_tag_o   = tail_idx;
  assign count_o       = count;

  assign head_ent = ent_q[head_idx];
  assign res_ent  = ent_q[resolve_tag_i];

  assign retire     = !flush_i && head_ent.valid && head_ent.resolved;
  assign mispred    = retire && bq_mispredict(head_ent);
  assign do_alloc   = !flush_i && !mispred && alloc_valid_i && alloc_ready_o;
  assign do_resolve = !flush_i && !mispred && resolve_valid_i &&
                      res_ent.valid && !res_ent.resolved;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (retire) head_d = head_q + PW'(1);
      // Squash leaves the queue empty right behind the retiring branch.
      if (mispred)       tail_d = head_q + PW'(1);
      else if (do_alloc) tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_i || mispred) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      if (retire) ent_q[head_idx].valid <= 1'b0;
      if (do_alloc) begin
        ent_q[tail_idx].valid       <= 1'b1;
        ent_q[tail_idx].resolved    <= 1'b0;
        ent_q[tail_idx].pc          <= alloc_pc_i;
        ent_q[tail_idx].pred_taken  <= alloc_pred_taken_i;
        ent_q[tail_idx].pred_target <= alloc_pred_target_i;
        ent_q[tail_idx].act_taken   <= 1'b0;
        ent_q[tail_idx].act_target  <= '0;
      end
      if (do_resolve) begin
        ent_q[resolve_tag_i].resolved   <= 1'b1;
        ent_q[resolve_tag_i].act_taken  <= resolve_taken_i;
        ent_q[resolve_tag_i].act_target <= resolve_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      update_en_q     <= 1'b0;
      mispredict_q    <= 1'b0;
      update_pc_q     <= '0;
      actual_taken_q  <= 1'b0;
      actual_target_q <= '0;
      redirect_pc_q   <= '0;
    end else begin
      update_en_q  <= retire;
      mispredict_q <= mispred;
      if (retire) begin
        update_pc_q     <= head_ent.pc;
        actual_taken_q  <= head_ent.act_taken;
        actual_target_q <= head_ent.act_target;
        redirect_pc_q   <= bq_redirect(head_ent);
      end
    end
  end

  assign update_en_o     = update_en_q;
  assign mispredict_o    = mispredict_q;
  assign update_pc_o     = update_pc_q;
  assign actual_taken_o  = actual_taken_q;
  assign actual_target_o = actual_target_q;
  assign redirect_pc_o   = redirect_pc_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: expected retires are queued by the
// stimulus and compared by an independent monitor on the falling edge.
module tb_branch_update_queue;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        alloc_valid_i = 1'b0;
  logic        alloc_ready_o;
  logic [31:0] alloc_pc_i = '0;
  logic        alloc_pred_taken_i = 1'b0;
  logic [31:0] alloc_pred_target_i = '0;
  logic [2:0]  alloc_tag_o;
  logic        resolve_valid_i = 1'b0;
  logic [2:0]  resolve_tag_i = '0;
  logic        resolve_taken_i = 1'b0;
  logic [31:0] resolve_target_i = '0;
  logic        flush_i = 1'b0;
  logic        update_en_o;
  logic [31:0] update_pc_o;
  logic        actual_taken_o;
  logic [31:0] actual_target_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [3:0]  count_o;

  branch_update_queue dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_pc_i(alloc_pc_i), .alloc_pred_taken_i(alloc_pred_taken_i),
    .alloc_pred_target_i(alloc_pred_target_i), .alloc_tag_o(alloc_tag_o),
    .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .flush_i(flush_i), .update_en_o(update_en_o), .update_pc_o(update_pc_o),
    .actual_taken_o(actual_taken_o), .actual_target_o(actual_target_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] redirect;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                            input logic mis, input logic [31:0] redirect);
    exp_t e;
    e.pc = pc; e.taken = taken; e.target = target; e.mis = mis; e.redirect = redirect;
    sb.push_back(e);
  endtask

  // Monitor: every update strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (reset_ni && mispredict_o) chk("mis_with_update", 32'(update_en_o), 32'd1);
      if (reset_ni && update_en_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got pc 0x%08h expected no update at %0t",
                   update_pc_o, $time);
        end else begin
          e = sb.pop_front();
          chk("upd_pc", update_pc_o, e.pc);
          chk("upd_taken", 32'(actual_taken_o), 32'(e.taken));
          if (e.taken) chk("upd_target", actual_target_o, e.target);
          chk("upd_mispredict", 32'(mispredict_o), 32'(e.mis));
          if (e.mis) chk("upd_redirect", redirect_pc_o, e.redirect);
        end
      end
    end
  end

  task automatic do_reset();
    reset_ni = 1'b0;
    alloc_valid_i = 1'b0;
    resolve_valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    alloc_valid_i = 1'b1;
    alloc_pc_i = pc;
    alloc_pred_taken_i = pt;
    alloc_pred_target_i = ptgt;
    @(posedge clk_i);
    #1 alloc_valid_i = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
    resolve_valid_i = 1'b1;
    resolve_tag_i = tag;
    resolve_taken_i = taken;
    resolve_target_i = tgt;
    @(posedge clk_i);
    #1 resolve_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk_i);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(alloc_ready_o), 32'd1);
    chk("rst_tag", 32'(alloc_tag_o), 32'd0);
    chk("rst_update_en", 32'(update_en_o), 32'd0);
    chk("rst_update_pc", update_pc_o, 32'd0);
    chk("rst_redirect", redirect_pc_o, 32'd0);

    // Single branch, correctly predicted not-taken; 2-cycle resolve-to-update
    alloc(32'h100, 1'b0, 32'h180);
    @(negedge clk_i);
    chk("t1_count_after_alloc", 32'(count_o), 32'd1);
    chk("t1_tag_after_alloc", 32'(alloc_tag_o), 32'd1);
    expect_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    resolve(3'd0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("t1_no_update_yet", 32'(update_en_o), 32'd0);
    @(negedge clk_i);
    chk("t1_update_latency", 32'(update_en_o), 32'd1);
    chk("t1_count_drained", 32'(count_o), 32'd0);

    // Out-of-order resolve, in-order retire on consecutive cycles
    do_reset();
    alloc(32'h10, 1'b0, 32'h0);
    alloc(32'h20, 1'b0, 32'h0);
    alloc(32'h30, 1'b0, 32'h0);
    expect_upd(32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
    expect_upd(32'h20, 1'b0, 32'h0, 1'b0, 32'h24);
    expect_upd(32'h30, 1'b0, 32'h0, 1'b0, 32'h34);
    resolve(3'd2, 1'b0, 32'h0);
    resolve(3'd0, 1'b0, 32'h0);
    resolve(3'd1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t2_back_to_back", 32'(update_en_o), 32'd1);
    end
    @(negedge clk_i);
    chk("t2_update_done", 32'(update_en_o), 32'd0);
    chk("t2_count", 32'(count_o), 32'd0);

    // Full queue, ignored 9th alloc, tag wrap, retire frees slot next cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk("t3_tag_seq", 32'(alloc_tag_o), 32'(i));
      alloc(32'h1000 + 32'(i) * 4, 1'b0, 32'h0);
    end
    @(negedge clk_i);
    chk("t3_full_ready", 32'(alloc_ready_o), 32'd0);
    chk("t3_full_count", 32'(count_o), 32'd8);
    chk("t3_tag_wrap", 32'(alloc_tag_o), 32'd0);
    alloc(32'hBAD0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("t3_ninth_ignored", 32'(count_o), 32'd8);
    expect_upd(32'h1000, 1'b0, 32'h0, 1'b0, 32'h1004);
    resolve(3'd0, 1'b0, 32'h0);
    alloc_valid_i = 1'b1;
    alloc_pc_i = 32'hDEAD;
    @(negedge clk_i);
    chk("t3_retire_no_free", 32'(alloc_ready_o), 32'd0);
    @(posedge clk_i);
    #1 alloc_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t3_ready_after_retire", 32'(alloc_ready_o), 32'd1);
    chk("t3_count_after_retire", 32'(count_o), 32'd7);
    chk("t3_tag_reuse", 32'(alloc_tag_o), 32'd0);
    alloc(32'h2000, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("t3_refill", 32'(count_o), 32'd8);

    // Target mispredict squashes younger entries and drops same-cycle traffic
    do_reset();
    alloc(32'h200, 1'b1, 32'h300);
    alloc(32'h210, 1'b0, 32'h0);
    alloc(32'h220, 1'b0, 32'h0);
    alloc(32'h230, 1'b0, 32'h0);
    expect_upd(32'h200, 1'b1, 32'h340, 1'b1, 32'h340);
    resolve(3'd0, 1'b1, 32'h340);
    alloc_valid_i = 1'b1;
    alloc_pc_i = 32'h999;
    resolve_valid_i = 1'b1;
    resolve_tag_i = 3'd1;
    resolve_taken_i = 1'b1;
    resolve_target_i = 32'h500;
    @(posedge clk_i);
    #1;
    alloc_valid_i = 1'b0;
    resolve_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_mispredict", 32'(mispredict_o), 32'd1);
    chk("t4_squash_count", 32'(count_o), 32'd0);
    chk("t4_tail_after_squash", 32'(alloc_tag_o), 32'd1);
    repeat (3) @(negedge clk_i);
    chk("t4_no_stray_update", 32'(update_en_o), 32'd0);

    // Direction mispredict: redirect to fall-through
    do_reset();
    alloc(32'h400, 1'b1, 32'h480);
    expect_upd(32'h400, 1'b0, 32'h0, 1'b1, 32'h404);
    resolve(3'd0, 1'b0, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t5_mispredict", 32'(mispredict_o), 32'd1);
    chk("t5_redirect", redirect_pc_o, 32'h404);
    @(negedge clk_i);
    chk("t5_strobe_one_cycle", 32'(mispredict_o), 32'd0);
    chk("t5_data_holds", redirect_pc_o, 32'h404);

    // Flush with four resolved entries emits no updates
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h800 + 32'(i) * 16, 1'b0, 32'h0);
    resolve(3'd3, 1'b0, 32'h0);
    resolve(3'd2, 1'b0, 32'h0);
    resolve(3'd1, 1'b0, 32'h0);
    resolve(3'd0, 1'b0, 32'h0);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("t6_flush_count", 32'(count_o), 32'd0);
    chk("t6_flush_no_update", 32'(update_en_o), 32'd0);
    chk("t6_flush_tag", 32'(alloc_tag_o), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("t6_still_quiet", 32'(update_en_o), 32'd0);

    // Asynchronous reset mid-stream clears outputs without a clock edge
    do_reset();
    alloc(32'h600, 1'b0, 32'h0);
    alloc(32'h610, 1'b0, 32'h0);
    resolve(3'd0, 1'b1, 32'h700);
    @(posedge clk_i);
    #1;
    chk("t7_pre_update", 32'(update_en_o), 32'd1);
    chk("t7_pre_redirect", redirect_pc_o, 32'h700);
    #1 reset_ni = 1'b0;
    #1;
    chk("t7_async_update_en", 32'(update_en_o), 32'd0);
    chk("t7_async_mispredict", 32'(mispredict_o), 32'd0);
    chk("t7_async_pc", update_pc_o, 32'd0);
    chk("t7_async_redirect", redirect_pc_o, 32'd0);
    chk("t7_async_count", 32'(count_o), 32'd0);
    chk("t7_async_ready", 32'(alloc_ready_o), 32'd1);
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

In-order branch resolution queue that drives the update side of the gshare predictor. Fetch allocates one entry per predicted branch, recording PC, predicted direction and predicted target. Execution units resolve entries out of order by tag. The queue retires resolved entries strictly in program order, producing one predictor update per cycle plus a misprediction redirect, and squashes wrong-path entries younger than a mispredicted branch.

## Interface
- DEPTH, 8, number of entries; power of two, at least 2
- TAG_WIDTH, $clog2(DEPTH), width of the entry tag
- clk_i  input  1  single clock; all state on its rising edge
- reset_ni  input  1  asynchronous, active-low reset
- alloc_valid_i  input  1  fetch presents a predicted branch
- alloc_ready_o  output  1  queue can accept an entry (count < DEPTH)
- alloc_pc_i  input  32  branch PC
- alloc_pred_taken_i  input  1  predicted direction
- alloc_pred_target_i  input  32  predicted target
- alloc_tag_o  output  TAG_WIDTH  tag the entry receives if allocated this cycle (tail index)
- resolve_valid_i  input  1  execution outcome valid
- resolve_tag_i  input  TAG_WIDTH  entry being resolved
- resolve_taken_i  input  1  actual direction
- resolve_target_i  input  32  actual target (computed taken target)
- flush_i  input  1  external pipeline flush; clears the queue
- update_en_o  output  1  one-cycle predictor update strobe
- update_pc_o  output  32  PC of the retired branch
- actual_taken_o  output  1  retired outcome
- actual_target_o  output  32  retired target
- mispredict_o  output  1  one-cycle strobe, coincident with update_en_o
- redirect_pc_o  output  32  correct fetch PC when mispredict_o is high
- count_o  output  TAG_WIDTH+1  occupied entries

## Operation
- Entry fields: valid, resolved, pc, pred_taken, pred_target, act_taken, act_target.
- Allocate: when alloc_valid_i && alloc_ready_o, write the tail entry with valid=1 and resolved=0, then advance the tail. Wrap modulo DEPTH.
- Resolve: when resolve_valid_i is high and the entry is valid and unresolved, store the outcome and set resolved. A resolve to an invalid or already-resolved entry is ignored.
- Retire: when the head entry is valid and resolved, clear it, advance the head, and register the update outputs. At most one retire per cycle.
- Mispredict condition: act_taken != pred_taken, or (act_taken && act_target != pred_target).
- redirect_pc_o is act_target if act_taken, else pc + 4 (mod 2^32).
- On a mispredicting retire, squash all younger entries: tail = head + 1 and all valid bits cleared. A same-cycle allocate is dropped. A same-cycle resolve to a younger entry is dropped.
- flush_i has the highest priority. It clears all valid bits and pointers and suppresses that cycle's retire, allocate and resolve. The update and mispredict strobes are low in the following cycle.
- Full: alloc_ready_o = 0, and a same-cycle retire does not free the slot for that cycle's allocation. Empty: no retire.
- Resolve and allocate in the same cycle are independent.
- Resolving the head in cycle N gives a retire decision in cycle N+1.

## Timing
- Reset (asynchronous, reset_ni low):
  - pointers = 0, count_o = 0, all valid bits = 0.
  - update_en_o = 0, mispredict_o = 0, update_pc_o = 0, actual_taken_o = 0, actual_target_o = 0, redirect_pc_o = 0.
  - alloc_ready_o = 1, alloc_tag_o = 0.
- Reset mid-operation discards every entry; no update is emitted.
- alloc_ready_o, alloc_tag_o and count_o are combinational from registered state. They do not depend on the same-cycle retire or flush.
- Update outputs are registered. For a head resolved at edge E, update_en_o is high in the cycle after edge E+1, so resolve-to-update latency is 2 cycles.
- update_en_o and mispredict_o are high for exactly one cycle per retire. The data outputs hold their last value otherwise.
- Sustained throughput: one allocate, one resolve and one retire per cycle.

## Structure
- Add typedef bq_entry_s (fields above) to structs.svh next to btb_entry_s.
- No sub-module: the entry array, pointers and retire logic form a single module.
- Pointers are TAG_WIDTH+1 bits (extra wrap bit); count_o = tail - head.

## Test plan
- Allocate a single branch (pc 0x100, pred not-taken), resolve it not-taken -> 2 cycles later update_en_o=1, update_pc_o=0x100, actual_taken_o=0, mispredict_o=0, count_o returns to 0.
- Allocate tags 0,1,2; resolve in order 2,0,1 -> updates emitted in tag order 0,1,2 on consecutive cycles after tag 1 resolves.
- Allocate 8 entries -> alloc_ready_o=0 and a 9th alloc_valid_i is ignored. Retire one -> alloc_ready_o=1 next cycle. alloc_tag_o wraps from 7 to 0.
- Entry pc 0x200, pred taken to 0x300, resolved taken to 0x340 -> mispredict_o=1, redirect_pc_o=0x340. 3 younger allocated entries are squashed and count_o=0. A same-cycle allocate is dropped.
- Entry pc 0x400, pred taken, resolved not-taken -> mispredict_o=1, redirect_pc_o=0x404.
- With 4 resolved entries, assert flush_i -> no update_en_o pulses and count_o=0. Separately, asserting reset_ni low mid-stream clears all outputs immediately without waiting for a clock edge.
